// File: rtl/csi_rx_vc_packet_handler.sv
// -----------------------------------------------------------------------------
// csi_rx_vc_packet_handler
//
// CSI-2 packet layer sitting behind the D-PHY word combiner on the word clock.
// Decodes packet headers, tracks frame/line state for up to four virtual
// channels, forwards video payload words tagged with their VC and drives the
// sync / packet-done handshake back to the aligners and combiner.
//
// Ports:
//   clock          word clock (only clock)
//   reset_n        synchronous active-low reset
//   enable         clock enable; low freezes state and masks pulse outputs
//   data           combined 32-bit word, byte 0 in [7:0]
//   data_enable    data valid this cycle
//   data_frame     combiner is inside a packet (informational only)
//   lp_detect      lane returned to LP state
//   sync_wait      aligners/combiner may accept a new SoT sync
//   packet_done    one-cycle pulse at packet end
//   payload*       video payload word with valid / keep / last / frame / VC
//   vsync          per-VC frame-start pulse
//   in_frame       per-VC frame flag (FS sets, FE clears)
//   in_line        per-VC flag while its video long packet is in progress
//   len_error      one-cycle pulse on timeout or early-LP abort
// -----------------------------------------------------------------------------
module csi_rx_vc_packet_handler #(
  parameter int         NUM_VC   = 1,
  parameter logic [5:0] FS_DT    = 6'h00,
  parameter logic [5:0] FE_DT    = 6'h01,
  parameter logic [5:0] VIDEO_DT = 6'h2A,
  parameter int         MAX_LEN  = 8192
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [31:0]       data,
  input  logic              data_enable,
  input  logic              data_frame,
  input  logic              lp_detect,
  output logic              sync_wait,
  output logic              packet_done,
  output logic [31:0]       payload,
  output logic              payload_enable,
  output logic [3:0]        payload_keep,
  output logic              payload_last,
  output logic              payload_frame,
  output logic [1:0]        payload_vc,
  output logic [NUM_VC-1:0] vsync,
  output logic [NUM_VC-1:0] in_frame,
  output logic [NUM_VC-1:0] in_line,
  output logic              len_error
);

  localparam logic [31:0] MAX_LEN_U = 32'(MAX_LEN);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    VIDEO     = 2'd1,
    SKIP      = 2'd2,
    DONE      = 2'd3
  } state_t;

  // One-hot mask of a VC; all zero for VCs that are not tracked (foreign).
  function automatic logic [NUM_VC-1:0] vc_onehot(input logic [1:0] vc);
    logic [NUM_VC-1:0] mask;
    mask = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      mask[i] = (vc == 2'(i));
    end
    return mask;
  endfunction

  // Byte-valid mask for the final word given the bytes still owed.
  function automatic logic [3:0] tail_keep(input logic [15:0] rem);
    logic [3:0] keep;
    case (rem)
      16'd1:   keep = 4'h1;
      16'd2:   keep = 4'h3;
      16'd3:   keep = 4'h7;
      default: keep = 4'hF;
    endcase
    return keep;
  endfunction

  state_t            state_r;
  logic [15:0]       remaining_r;
  logic [15:0]       cnt_r;
  logic [1:0]        vc_r;
  logic              sync_wait_r;
  logic              packet_done_r;
  logic [31:0]       payload_r;
  logic              payload_enable_r;
  logic [3:0]        payload_keep_r;
  logic              payload_last_r;
  logic              payload_frame_r;
  logic [1:0]        payload_vc_r;
  logic [NUM_VC-1:0] vsync_r;
  logic [NUM_VC-1:0] in_frame_r;
  logic [NUM_VC-1:0] in_line_r;
  logic              len_error_r;

  logic [1:0]        hdr_vc_s;
  logic [5:0]        hdr_dt_s;
  logic [15:0]       hdr_wc_s;
  logic [NUM_VC-1:0] vc_mask_s;
  logic              is_tail_s;
  logic              last_word_s;
  logic [16:0]       cnt_inc_s;
  logic              timeout_s;
  logic              abort_s;
  logic [15:0]       rem_next_s;
  logic [15:0]       cnt_sat_s;

  // The combiner's frame flag and the header ECC byte carry nothing we act on.
  logic unused_s;
  assign unused_s = &{1'b0, data_frame, data[31:24]};

  // Header decode, word accounting and abort conditions.
  always_comb begin
    hdr_vc_s    = data[7:6];
    hdr_dt_s    = data[5:0];
    hdr_wc_s    = data[23:8];
    vc_mask_s   = vc_onehot(hdr_vc_s);
    is_tail_s   = (remaining_r <= 16'd4);
    last_word_s = data_enable && is_tail_s;
    cnt_inc_s   = {1'b0, cnt_r} + 17'd1;
    // Timeout fires at the end of the MAX_LEN-th cycle spent in the packet body.
    timeout_s   = ({15'd0, cnt_inc_s} >= MAX_LEN_U);
    // A last word arriving in the same cycle completes the packet normally.
    abort_s     = !last_word_s && (timeout_s || lp_detect);
    if (is_tail_s) begin
      rem_next_s = 16'd0;
    end else begin
      rem_next_s = remaining_r - 16'd4;
    end
    if (cnt_r == 16'hFFFF) begin
      cnt_sat_s = cnt_r;
    end else begin
      cnt_sat_s = cnt_inc_s[15:0];
    end
  end

  // Packet FSM with all outputs registered alongside the state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r          <= WAIT_SYNC;
      remaining_r      <= 16'd0;
      cnt_r            <= 16'd0;
      vc_r             <= 2'd0;
      sync_wait_r      <= 1'b1;
      packet_done_r    <= 1'b0;
      payload_r        <= 32'd0;
      payload_enable_r <= 1'b0;
      payload_keep_r   <= 4'h0;
      payload_last_r   <= 1'b0;
      payload_frame_r  <= 1'b0;
      payload_vc_r     <= 2'd0;
      vsync_r          <= '0;
      in_frame_r       <= '0;
      in_line_r        <= '0;
      len_error_r      <= 1'b0;
    end else if (enable) begin
      vsync_r          <= '0;
      packet_done_r    <= 1'b0;
      len_error_r      <= 1'b0;
      payload_enable_r <= 1'b0;
      payload_last_r   <= 1'b0;
      case (state_r)
        WAIT_SYNC: begin
          if (data_enable) begin
            sync_wait_r <= 1'b0;
            if (hdr_dt_s < 6'h10) begin
              if (hdr_dt_s == FS_DT) begin
                in_frame_r <= in_frame_r | vc_mask_s;
                vsync_r    <= vc_mask_s;
              end else if (hdr_dt_s == FE_DT) begin
                in_frame_r <= in_frame_r & ~vc_mask_s;
              end
              state_r       <= DONE;
              packet_done_r <= 1'b1;
            end else begin
              remaining_r <= hdr_wc_s;
              cnt_r       <= 16'd0;
              if ((hdr_dt_s == VIDEO_DT) && (vc_mask_s != '0)) begin
                vc_r      <= hdr_vc_s;
                in_line_r <= vc_mask_s;
                if (hdr_wc_s == 16'd0) begin
                  state_r       <= DONE;
                  packet_done_r <= 1'b1;
                end else begin
                  state_r         <= VIDEO;
                  payload_frame_r <= 1'b1;
                end
              end else if (hdr_wc_s == 16'd0) begin
                state_r       <= DONE;
                packet_done_r <= 1'b1;
              end else begin
                state_r <= SKIP;
              end
            end
          end
        end
        VIDEO, SKIP: begin
          cnt_r <= cnt_sat_s;
          if (abort_s) begin
            len_error_r     <= 1'b1;
            packet_done_r   <= 1'b1;
            payload_frame_r <= 1'b0;
            state_r         <= DONE;
          end else if (data_enable) begin
            if (state_r == VIDEO) begin
              payload_r        <= data;
              payload_enable_r <= 1'b1;
              payload_keep_r   <= tail_keep(remaining_r);
              payload_last_r   <= is_tail_s;
              payload_vc_r     <= vc_r;
            end
            remaining_r <= rem_next_s;
            if (is_tail_s) begin
              packet_done_r   <= 1'b1;
              payload_frame_r <= 1'b0;
              state_r         <= DONE;
            end
          end
        end
        DONE: begin
          in_line_r   <= '0;
          sync_wait_r <= 1'b1;
          state_r     <= WAIT_SYNC;
        end
        default: begin
          sync_wait_r <= 1'b1;
          state_r     <= WAIT_SYNC;
        end
      endcase
    end
  end

  // Level outputs straight from their registers; pulses are masked while frozen.
  assign sync_wait      = sync_wait_r;
  assign payload        = payload_r;
  assign payload_keep   = payload_keep_r;
  assign payload_frame  = payload_frame_r;
  assign payload_vc     = payload_vc_r;
  assign in_frame       = in_frame_r;
  assign in_line        = in_line_r;
  assign packet_done    = packet_done_r & enable;
  assign payload_enable = payload_enable_r & enable;
  assign payload_last   = payload_last_r & enable;
  assign len_error      = len_error_r & enable;
  assign vsync          = vsync_r & {NUM_VC{enable}};

endmodule
